// File: rtl/iq_capture_pkg.sv
// Shared definitions for the RX capture path and the TX sampler.
// Holds the one-hot state encoding and the divider reload derivation.
package iq_capture_pkg;

  localparam int unsigned S_IDLE = 0;
  localparam int unsigned S_WR_I = 1;
  localparam int unsigned S_WR_Q = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'(1 << S_IDLE),
    ST_WR_I = 3'(1 << S_WR_I),
    ST_WR_Q = 3'(1 << S_WR_Q)
  } state_e;

  // Divider reload for one strobe per sample period; callers must keep it >= 2.
  function automatic logic [15:0] count_from_rates(input int unsigned clock_rate,
                                                   input int unsigned sample_rate);
    return 16'(clock_rate / sample_rate - 1);
  endfunction

endpackage

// File: rtl/iq_capture_rate_strobe.sv
// Sample-rate divider: one-cycle strobe every COUNT+1 enabled cycles.
// Held at reload while disabled so a restart gives a full period.
module iq_capture_rate_strobe
  import iq_capture_pkg::*;
#(
  parameter int unsigned CLOCK_RATE  = 100_000_000,
  parameter int unsigned SAMPLE_RATE = 10_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic stb_o
);

  localparam logic [15:0] COUNT = count_from_rates(CLOCK_RATE, SAMPLE_RATE);

  logic [15:0] cnt_q, cnt_d;
  logic        stb_q, stb_d;

  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    stb_d = 1'b0;
    if (!enable_i) begin
      cnt_d = COUNT;
    end else if (cnt_q == 16'd0) begin
      cnt_d = COUNT;
      stb_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= COUNT;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign stb_o = stb_q;

endmodule

// File: rtl/iq_capture.sv
// ADC I/Q capture into the RX byte FIFO: one pair per sample strobe, I then Q.
// A pair is dropped whole when the FIFO lacks two free slots; drops are counted.
module iq_capture
  import iq_capture_pkg::*;
#(
  parameter int unsigned CLOCK_RATE  = 100_000_000,
  parameter int unsigned SAMPLE_RATE = 10_000,
  parameter int unsigned OVR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       adc_i,
  input  logic [7:0]       adc_q,
  input  logic             fifo_full,
  input  logic             fifo_almost_full,
  output logic             fifo_wr,
  output logic [7:0]       fifo_data_in,
  output logic             overrun,
  output logic [OVR_W-1:0] ovr_count,
  input  logic             ovr_clear
);

  logic stb;

  iq_capture_rate_strobe #(
    .CLOCK_RATE (CLOCK_RATE),
    .SAMPLE_RATE(SAMPLE_RATE)
  ) u_rate_strobe (
    .clk     (clk),
    .rst     (rst),
    .enable_i(enable),
    .stb_o   (stb)
  );

  state_e           state_q, state_d;
  logic [7:0]       hold_i_q, hold_i_d;
  logic [7:0]       hold_q_q, hold_q_d;
  logic             wr_q, wr_d;
  logic [7:0]       data_q, data_d;
  logic             ovr_q, ovr_d;
  logic [OVR_W-1:0] cnt_q, cnt_d;
  logic             drop;

  always_comb begin
    state_d  = state_q;
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    drop     = 1'b0;

    // Flags are only consulted at the strobe; an accepted pair always finishes.
    case (state_q)
      ST_IDLE: begin
        if (stb) begin
          if (fifo_full || fifo_almost_full) begin
            drop = 1'b1;
          end else begin
            hold_i_d = adc_i;
            hold_q_d = adc_q;
            state_d  = ST_WR_I;
          end
        end
      end
      ST_WR_I: begin
        wr_d    = 1'b1;
        data_d  = hold_i_q;
        state_d = ST_WR_Q;
      end
      ST_WR_Q: begin
        wr_d    = 1'b1;
        data_d  = hold_q_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      ovr_d = 1'b1;
      if (ovr_clear)           cnt_d = OVR_W'(1);
      else if (cnt_q != '1)    cnt_d = cnt_q + OVR_W'(1);
    end else if (ovr_clear) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      // NOTE: the hold registers are two bytes, so they are reset like the rest rather than left to power-up values.
      hold_i_q <= 8'd0;
      hold_q_q <= 8'd0;
      wr_q     <= 1'b0;
      data_q   <= 8'd0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_i_q <= hold_i_d;
      hold_q_q <= hold_q_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fifo_wr      = wr_q;
  assign fifo_data_in = data_q;
  assign overrun      = ovr_q;
  assign ovr_count    = cnt_q;

endmodule

// File: tb/tb_iq_capture.sv
// Directed bench for iq_capture with COUNT=9: one 10-cycle window per sample pair,
// aligned so the strobe is seen at the window's first edge.
module tb_iq_capture;

  localparam int OVR_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [7:0]       adc_i, adc_q;
  logic             fifo_full, fifo_almost_full;
  logic             fifo_wr;
  logic [7:0]       fifo_data_in;
  logic             overrun;
  logic [OVR_W-1:0] ovr_count;
  logic             ovr_clear;

  always #5 clk = ~clk;

  iq_capture #(
    .CLOCK_RATE (10),
    .SAMPLE_RATE(1),
    .OVR_W      (OVR_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .adc_i           (adc_i),
    .adc_q           (adc_q),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .fifo_wr         (fifo_wr),
    .fifo_data_in    (fifo_data_in),
    .overrun         (overrun),
    .ovr_count       (ovr_count),
    .ovr_clear       (ovr_clear)
  );

  typedef struct {
    logic [7:0]       i;
    logic [7:0]       q;
    logic             af;
    logic             f;
    logic             exp_acc;
    logic             exp_ovr;
    logic [OVR_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered just after a negedge; the strobe is taken at the window's first posedge.
  task automatic run_window(input logic [7:0] i, input logic [7:0] q, input logic af,
                            input logic f, input logic full_mid, input int clear_at,
                            input int en_off_at, output int n_wr, output logic [7:0] b0,
                            output logic [7:0] b1, output int p0, output int p1);
    n_wr = 0; b0 = 8'd0; b1 = 8'd0; p0 = -1; p1 = -1;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        adc_i = i; adc_q = q; fifo_almost_full = af; fifo_full = f;
      end else begin
        adc_i = ~i; adc_q = ~q;
        if (full_mid) fifo_full = 1'b1;
      end
      ovr_clear = (k == clear_at);
      enable    = (k < en_off_at);
      @(posedge clk);
      @(negedge clk);
      if (fifo_wr) begin
        if (n_wr == 0) begin b0 = fifo_data_in; p0 = k; end
        else if (n_wr == 1) begin b1 = fifo_data_in; p1 = k; end
        n_wr++;
      end
    end
    ovr_clear = 1'b0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
  endtask

  task automatic do_pair(input string name, input logic [7:0] i, input logic [7:0] q,
                         input logic af, input logic f, input logic full_mid,
                         input int clear_at, input int en_off_at, input logic exp_acc,
                         input logic exp_ovr, input logic [OVR_W-1:0] exp_cnt);
    int n_wr, p0, p1;
    logic [7:0] b0, b1;
    run_window(i, q, af, f, full_mid, clear_at, en_off_at, n_wr, b0, b1, p0, p1);
    check({name, " writes"}, 32'(n_wr), exp_acc ? 32'd2 : 32'd0);
    if (exp_acc) begin
      check({name, " I byte"}, 32'(b0), 32'(i));
      check({name, " Q byte"}, 32'(b1), 32'(q));
      check({name, " I cycle"}, 32'(p0), 32'd1);
      check({name, " Q cycle"}, 32'(p1), 32'd2);
    end
    check({name, " overrun"}, 32'(overrun), 32'(exp_ovr));
    check({name, " ovr_count"}, 32'(ovr_count), 32'(exp_cnt));
  endtask

  task automatic idle(input int n, output int n_wr);
    n_wr = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (fifo_wr) n_wr++;
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[1] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1};
    vecs[3] = '{8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};

    rst = 1'b1; enable = 1'b0; adc_i = 8'h00; adc_q = 8'h00;
    fifo_full = 1'b0; fifo_almost_full = 1'b0; ovr_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset fifo_wr", 32'(fifo_wr), 32'd0);
    check("reset fifo_data_in", 32'(fifo_data_in), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset ovr_count", 32'(ovr_count), 32'd0);

    rst = 1'b0; enable = 1'b1;
    idle(10, n);
    check("first period silent", 32'(n), 32'd0);

    for (int v = 0; v < 6; v++)
      do_pair($sformatf("vec%0d", v), vecs[v].i, vecs[v].q, vecs[v].af, vecs[v].f, 1'b0,
              -1, 99, vecs[v].exp_acc, vecs[v].exp_ovr, vecs[v].exp_cnt);

    do_pair("clear idle",      8'h11, 8'h22, 1'b0, 1'b0, 1'b0,  5, 99, 1'b1, 1'b0, 4'h0);
    do_pair("full mid pair",   8'hC3, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 99, 1'b1, 1'b0, 4'h0);
    do_pair("drop a",          8'h44, 8'h55, 1'b1, 1'b0, 1'b0, -1, 99, 1'b0, 1'b1, 4'h1);
    do_pair("drop b",          8'h44, 8'h55, 1'b1, 1'b0, 1'b0, -1, 99, 1'b0, 1'b1, 4'h2);
    do_pair("clear with drop", 8'h44, 8'h55, 1'b1, 1'b0, 1'b0,  0, 99, 1'b0, 1'b1, 4'h1);
    do_pair("clear again",     8'h66, 8'h77, 1'b0, 1'b0, 1'b0,  5, 99, 1'b1, 1'b0, 4'h0);

    for (int d = 0; d < 14; d++)
      do_pair($sformatf("ramp drop%0d", d), 8'h99, 8'h88, 1'b1, 1'b0, 1'b0, -1, 99,
              1'b0, 1'b1, OVR_W'(d + 1));
    for (int d = 0; d < 3; d++)
      do_pair($sformatf("sat drop%0d", d), 8'h99, 8'h88, 1'b0, 1'b1, 1'b0, -1, 99,
              1'b0, 1'b1, 4'hF);

    // Reset while the I byte is due: no write, everything back to reset values.
    adc_i = 8'h5A; adc_q = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst mid fifo_wr", 32'(fifo_wr), 32'd0);
    check("rst mid fifo_data_in", 32'(fifo_data_in), 32'd0);
    check("rst mid overrun", 32'(overrun), 32'd0);
    check("rst mid ovr_count", 32'(ovr_count), 32'd0);
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (fifo_wr) break;
    end
    check("cycles rst to I write", 32'(n), 32'd12);
    check("post rst I byte", 32'(fifo_data_in), 32'h5A);
    idle(8, n);
    check("post rst Q write", 32'(n), 32'd1);

    do_pair("enable drop mid", 8'hDE, 8'hAD, 1'b0, 1'b0, 1'b0, -1, 1, 1'b1, 1'b0, 4'h0);
    idle(30, n);
    check("disabled writes", 32'(n), 32'd0);
    enable = 1'b1;
    idle(10, n);
    check("reenable silent", 32'(n), 32'd0);
    do_pair("reenable pair", 8'hBE, 8'hEF, 1'b0, 1'b0, 1'b0, -1, 99, 1'b1, 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
